// File: rtl/cnn_two_layer_sequencer_if.sv
// Control/address bundle between the two-layer CNN sequencer and its host/ROM/core side.
// The master side is the sequencer; the slave side is the host, ROMs and CNN core.
interface cnn_two_layer_sequencer_if #(
  parameter int AW = 6
);
  logic          start;
  logic          busy;
  logic          done;
  logic [AW-1:0] img_addr;
  logic [AW-1:0] flt1_addr;
  logic [AW-1:0] flt2_addr;
  logic          Start1;
  logic          ReadEn1;
  logic          Start2;
  logic          ReadEn2;
  logic          out_valid;
  logic [AW-1:0] out_idx;

  modport master (
    input  start,
    output busy, done, img_addr, flt1_addr, flt2_addr,
           Start1, ReadEn1, Start2, ReadEn2, out_valid, out_idx
  );

  modport slave (
    output start,
    input  busy, done, img_addr, flt1_addr, flt2_addr,
           Start1, ReadEn1, Start2, ReadEn2, out_valid, out_idx
  );
endinterface

// File: rtl/cnn_two_layer_sequencer.sv
// Run scheduler for the two-layer convolution core: load 1, compute 1, drain 1/load 2, compute 2, drain 2.
// Optional PERF_CNT_EN adds a saturating run_cycles busy-cycle counter.
module cnn_two_layer_sequencer #(
  parameter int IMG_N  = 36,
  parameter int FLT_N  = 9,
  parameter int L1_OUT = 16,
  parameter int L2_OUT = 4,
  parameter int C1_LAT = 4,
  parameter int C2_LAT = 4,
  parameter int AW     = 6
) (
  input  logic clk,
  input  logic rst,
`ifdef PERF_CNT_EN
  output logic [15:0] run_cycles,
`endif
  cnn_two_layer_sequencer_if.master bus
);

  localparam logic [AW-1:0] IMG_LAST = AW'(IMG_N - 1);
  localparam logic [AW-1:0] FLT_LAST = AW'(FLT_N - 1);
  localparam logic [AW-1:0] L1_LAST  = AW'(L1_OUT - 1);
  localparam logic [AW-1:0] L2_LAST  = AW'(L2_OUT - 1);
  localparam logic [AW-1:0] C1_LAST  = AW'((C1_LAT > 0) ? C1_LAT - 1 : 0);
  localparam logic [AW-1:0] C2_LAST  = AW'((C2_LAT > 0) ? C2_LAT - 1 : 0);

  if (IMG_N < FLT_N) begin : g_chk_img
    $error("IMG_N must be >= FLT_N");
  end
  if (L1_OUT < FLT_N) begin : g_chk_l1
    $error("L1_OUT must be >= FLT_N");
  end
  if ((2 ** AW) < IMG_N) begin : g_chk_aw
    $error("AW too small for IMG_N");
  end

  typedef enum logic [2:0] {
    IDLE,
    LOAD1,
    WAIT1,
    XFER,
    WAIT2,
    DRAIN,
    DONE
  } state_t;

  state_t        state, nxt_state;
  logic [AW-1:0] cnt, nxt_cnt;

  function automatic logic [AW-1:0] clamp_flt(input logic [AW-1:0] a);
    return (a > FLT_LAST) ? FLT_LAST : a;
  endfunction

  // Zero-length wait phases are skipped entirely rather than lasting one cycle.
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt + 1'b1;
    case (state)
      IDLE: begin
        nxt_cnt = '0;
        if (bus.start) nxt_state = LOAD1;
      end
      LOAD1: if (cnt == IMG_LAST) begin
        nxt_cnt   = '0;
        nxt_state = (C1_LAT == 0) ? XFER : WAIT1;
      end
      WAIT1: if (cnt == C1_LAST) begin
        nxt_cnt   = '0;
        nxt_state = XFER;
      end
      XFER: if (cnt == L1_LAST) begin
        nxt_cnt   = '0;
        nxt_state = (C2_LAT == 0) ? DRAIN : WAIT2;
      end
      WAIT2: if (cnt == C2_LAST) begin
        nxt_cnt   = '0;
        nxt_state = DRAIN;
      end
      DRAIN: if (cnt == L2_LAST) begin
        nxt_cnt   = '0;
        nxt_state = DONE;
      end
      default: begin
        nxt_cnt   = '0;
        nxt_state = IDLE;
      end
    endcase
  end

  // Outputs decode the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.img_addr  <= '0;
      bus.flt1_addr <= '0;
      bus.flt2_addr <= '0;
      bus.Start1    <= 1'b0;
      bus.ReadEn1   <= 1'b0;
      bus.Start2    <= 1'b0;
      bus.ReadEn2   <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_idx   <= '0;
    end else begin
      state         <= nxt_state;
      cnt           <= nxt_cnt;
      bus.busy      <= (nxt_state != IDLE);
      bus.done      <= (nxt_state == DONE);
      bus.Start1    <= (nxt_state == LOAD1);
      bus.img_addr  <= (nxt_state == LOAD1) ? nxt_cnt : '0;
      bus.flt1_addr <= (nxt_state == LOAD1) ? clamp_flt(nxt_cnt) : '0;
      bus.ReadEn1   <= (nxt_state == XFER);
      bus.Start2    <= (nxt_state == XFER);
      bus.flt2_addr <= (nxt_state == XFER) ? clamp_flt(nxt_cnt) : '0;
      bus.ReadEn2   <= (nxt_state == DRAIN);
      bus.out_valid <= (state == DRAIN);
      bus.out_idx   <= (state == DRAIN) ? cnt : '0;
    end
  end

`ifdef PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      run_cycles <= '0;
    end else if (state == IDLE && bus.start) begin
      run_cycles <= '0;
    end else if (bus.busy && run_cycles != 16'hFFFF) begin
      run_cycles <= run_cycles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cnn_two_layer_sequencer.sv
// Self-checking bench for cnn_two_layer_sequencer: default instance plus a C1_LAT=0/C2_LAT=7 instance.
module tb_cnn_two_layer_sequencer;
  localparam int AW     = 6;
  localparam int IMG_N  = 36;
  localparam int FLT_N  = 9;
  localparam int L1_OUT = 16;
  localparam int L2_OUT = 4;

  typedef struct packed {
    logic          busy;
    logic          done;
    logic          s1;
    logic          r1;
    logic          s2;
    logic          r2;
    logic          ov;
    logic [AW-1:0] img;
    logic [AW-1:0] f1;
    logic [AW-1:0] f2;
    logic [AW-1:0] idx;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  cnn_two_layer_sequencer_if #(.AW(AW)) bus_a ();
  cnn_two_layer_sequencer_if #(.AW(AW)) bus_b ();

`ifdef PERF_CNT_EN
  logic [15:0] rc_a, rc_b;
`endif

  cnn_two_layer_sequencer #(.AW(AW)) dut_a (
    .clk(clk),
    .rst(rst),
`ifdef PERF_CNT_EN
    .run_cycles(rc_a),
`endif
    .bus(bus_a)
  );

  cnn_two_layer_sequencer #(.C1_LAT(0), .C2_LAT(7), .AW(AW)) dut_b (
    .clk(clk),
    .rst(rst),
`ifdef PERF_CNT_EN
    .run_cycles(rc_b),
`endif
    .bus(bus_b)
  );

  function automatic obs_t get_obs(input bit sel);
    obs_t o;
    if (sel)
      o = {bus_b.busy, bus_b.done, bus_b.Start1, bus_b.ReadEn1, bus_b.Start2, bus_b.ReadEn2,
           bus_b.out_valid, bus_b.img_addr, bus_b.flt1_addr, bus_b.flt2_addr, bus_b.out_idx};
    else
      o = {bus_a.busy, bus_a.done, bus_a.Start1, bus_a.ReadEn1, bus_a.Start2, bus_a.ReadEn2,
           bus_a.out_valid, bus_a.img_addr, bus_a.flt1_addr, bus_a.flt2_addr, bus_a.out_idx};
    return o;
  endfunction

  // Expected outputs t cycles after the edge that accepted start, from the phase lengths.
  function automatic obs_t model(input int t, input int c1, input int c2);
    obs_t e;
    int xs, ds, dn;
    e  = '0;
    xs = IMG_N + c1;
    ds = xs + L1_OUT + c2;
    dn = ds + L2_OUT;
    e.busy = (t >= 0 && t <= dn);
    e.done = (t == dn);
    if (t >= 0 && t < IMG_N) begin
      e.s1  = 1'b1;
      e.img = AW'(t);
      e.f1  = AW'((t < FLT_N) ? t : FLT_N - 1);
    end
    if (t >= xs && t < xs + L1_OUT) begin
      e.r1 = 1'b1;
      e.s2 = 1'b1;
      e.f2 = AW'((t - xs < FLT_N) ? t - xs : FLT_N - 1);
    end
    if (t >= ds && t < dn) e.r2 = 1'b1;
    if (t > ds && t <= dn) begin
      e.ov  = 1'b1;
      e.idx = AW'(t - ds - 1);
    end
    return e;
  endfunction

  task automatic chk(input string tag, input int t, input obs_t o, input obs_t e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s t=%0d got %h expected %h", tag, t, o, e);
    end
  endtask

  task automatic chk_int(input string tag, input int got, input int exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_start(input bit sel, input bit v);
    if (sel) bus_b.start = v;
    else     bus_a.start = v;
  endtask

  // One run: optional idle lead-in and start pulse, then per-cycle comparison against the model.
  task automatic run(input bit sel, input int c1, input int c2, input bit pre,
                     input bit hold, input bit noise, input int abort_at);
    obs_t o, e;
    int   xs, dn, t_done, n_idle;
    bit   s;
    xs     = IMG_N + c1;
    dn     = xs + L1_OUT + c2 + L2_OUT;
    t_done = -1;
    if (!pre) begin
      n_idle = int'($urandom_range(1, 4));
      for (int i = 0; i < n_idle; i++) begin
        @(negedge clk);
        chk("idle", -1, get_obs(sel), '0);
      end
      set_start(sel, 1'b1);
    end
    for (int t = 0; t <= dn + 1; t++) begin
      @(negedge clk);
      o = get_obs(sel);
      e = model(t, c1, c2);
      chk("cycle", t, o, e);
      if (o.done && t_done < 0) t_done = t;
`ifdef PERF_CNT_EN
      if (!sel && t == 0)      chk_int("perf_clear", int'(rc_a), 0);
      if (!sel && t == dn + 1) chk_int("perf_total", int'(rc_a), dn + 1);
`endif
      if (t == abort_at) begin
        rst = 1'b1;
        set_start(sel, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_abort", t, get_obs(sel), '0);
`ifdef PERF_CNT_EN
        chk_int("perf_rst", int'(rc_a), 0);
`endif
        for (int i = 0; i < 6; i++) begin
          @(negedge clk);
          chk("no_done", i, get_obs(sel), '0);
        end
        return;
      end
      if (t <= dn) begin
        s = hold ? 1'b1 : (noise ? 1'($urandom_range(0, 1)) : 1'b0);
        if (noise && (t == xs + 8 || t == dn)) s = 1'b1;
      end else begin
        s = hold;
      end
      set_start(sel, s);
    end
    chk_int("latency", t_done + 2, 1 + IMG_N + c1 + L1_OUT + c2 + L2_OUT + 1);
  endtask

  initial begin
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_a", 0, get_obs(1'b0), '0);
    chk("reset_b", 0, get_obs(1'b1), '0);
`ifdef PERF_CNT_EN
    chk_int("perf_reset", int'(rc_a), 0);
`endif
    rst = 1'b0;

    run(1'b0, 4, 4, 1'b0, 1'b0, 1'b0, -1);
`ifdef PERF_CNT_EN
    repeat (3) @(negedge clk);
    chk_int("perf_hold", int'(rc_a), IMG_N + 4 + L1_OUT + 4 + L2_OUT + 1);
`endif
    run(1'b0, 4, 4, 1'b0, 1'b0, 1'b1, -1);
    run(1'b0, 4, 4, 1'b0, 1'b1, 1'b0, -1);
    run(1'b0, 4, 4, 1'b1, 1'b0, 1'b0, -1);
    run(1'b0, 4, 4, 1'b0, 1'b0, 1'b0, IMG_N + int'($urandom_range(0, 3)));
    run(1'b0, 4, 4, 1'b0, 1'b0, 1'b0, -1);
    run(1'b1, 0, 7, 1'b0, 1'b0, 1'b1, -1);
    chk("idle_a_end", 0, get_obs(1'b0), '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
